traffic_light_ndir: RTL and testbench
=====================================

// Module: traffic_light_ndir
// PURPOSE
//  Parametrised successor to the two-way NS/EW controller. Round-robins NUM_DIR
//  approaches through GREEN -> YELLOW -> ALL-RED phases, timed in ticks of an
//  external 1-cycle 'tick' strobe. Adds a green-extend hold input and an
//  optional emergency pre-emption. Sits between the tick divider and the lamp drivers.
// PARAMETERS
//  NUM_DIR       3  number of approaches, 2..8
//  GREEN_TICKS   5  ticks per green phase, >=1
//  YELLOW_TICKS  2  ticks per yellow phase, >=1
//  ALLRED_TICKS  1  ticks of all-red clearance, >=0 (0 = phase skipped)
// PORTS
//  clk          in   1                 system clock
//  rst          in   1                 asynchronous reset, active-high
//  tick         in   1                 1-cycle timing strobe, sampled on posedge clk
//  hold         in   1                 extend current green while high
//  g            out  NUM_DIR           green lamp per direction
//  y            out  NUM_DIR           yellow lamp per direction
//  r            out  NUM_DIR           red lamp per direction
//  active_dir   out  $clog2(NUM_DIR)   index of direction owning the phase
//  phase        out  2                 phase_t of current phase
//  preempt      in   1                 [TRAFFIC_PREEMPT_EN only] pre-emption request
//  preempt_dir  in   $clog2(NUM_DIR)   [TRAFFIC_PREEMPT_EN only] direction to serve
// BEHAVIOUR
//  - Reset (async, immediate): phase=GREEN, active_dir=0, cnt=0; g=1<<0, y=0, r=~(1<<0).
//  - State/cnt/outputs registered; all change only on posedge clk with tick=1.
//  - Per direction exactly one of g/y/r high; non-active directions always red.
//  - GREEN: cnt==GREEN_TICKS-1 & tick & !hold -> YELLOW, cnt=0; else cnt++ on tick.
//    hold with cnt at terminal: stay GREEN, cnt saturates. hold ignored elsewhere.
//  - YELLOW: cnt==YELLOW_TICKS-1 & tick -> ALLRED (or GREEN of next dir if ALLRED_TICKS==0).
//  - ALLRED: all r=1; cnt==ALLRED_TICKS-1 & tick -> GREEN, active_dir=next, cnt=0.
//  - next = active_dir+1, wraps NUM_DIR-1 -> 0.
//  - cnt width = $clog2(max of tick params)+1; no overflow possible.
//  - tick=0: no state change regardless of hold/preempt.
//  - Reset mid-phase discards cnt and direction; restart at dir 0 green.
// CONFIGURATION
//  TRAFFIC_PREEMPT_EN defined: preempt/preempt_dir ports exist.
//   - preempt in GREEN with active_dir!=preempt_dir: next tick -> YELLOW, cnt=0.
//   - preempt in YELLOW/ALLRED: phases complete normally; next = preempt_dir.
//   - preempt in GREEN with active_dir==preempt_dir: stay GREEN, cnt frozen.
//   - Release: normal timing resumes from current cnt. preempt beats hold.
//   - preempt_dir >= NUM_DIR: request ignored.
//  Undefined: ports absent; pure round-robin timing above.
// STRUCTURE
//  traffic_pkg: typedef enum logic[1:0] phase_t {PH_GREEN=0, PH_YELLOW=1,
//   PH_ALLRED=2}; function next_dir(). Shared with future controllers.
//  Sub-module traffic_phase_timer: tick counter with load/terminal/saturate,
//   parametrised by width; FSM and lamp decode stay in top.
// TESTING (defaults, tick every 100 clk)
//  1 Reset: rst=1 -> g=3'b001, r=3'b110, phase=0, active_dir=0 before any clk edge.
//  2 Rotation: 24 ticks -> dir0 G5/Y2/AR1, dir1, dir2, back to dir0 green at tick 24.
//  3 Hold: hold=1 from tick 3 to 10 -> dir0 green to tick 10; yellow at next tick.
//  4 Mid reset: rst pulse during dir2 yellow -> immediate dir0 green, cnt=0.
//  5 ALLRED_TICKS=0 build: yellow of dir0 -> dir1 green at tick 7; never all-red.
//  6 PREEMPT_EN: preempt=1, preempt_dir=2 at dir0 green tick 1 -> yellow at
//    tick 2, all-red, dir2 green at tick 5, held until preempt=0.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types and helpers for the traffic light controllers.
// Phase encoding and direction rotation used by every controller variant.
package traffic_pkg;

  typedef enum logic [1:0] {
    PH_GREEN  = 2'd0,
    PH_YELLOW = 2'd1,
    PH_ALLRED = 2'd2
  } phase_t;

  function automatic int unsigned next_dir(
    input int unsigned cur,
    input int unsigned num
  );
    return (cur + 1 >= num) ? 0 : cur + 1;
  endfunction

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/traffic_phase_timer.sv
// Tick-qualified phase counter with clear, terminal flag and saturation.
// Counting stops at the terminal value until the owner reloads it.
module traffic_phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic         load,
  input  logic         inc,
  input  logic [W-1:0] term,
  output logic         at_term
);

  logic [W-1:0] cnt;

  assign at_term = (cnt == term);

  // Clear on load, else count up on tick and saturate at the terminal value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      if (load) begin
        cnt <= '0;
      end else if (inc && !at_term) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/traffic_light_ndir.sv
// N-approach round-robin traffic light: green/yellow/all-red per direction.
// Optional emergency pre-emption is built when TRAFFIC_PREEMPT_EN is defined.
module traffic_light_ndir
  import traffic_pkg::*;
#(
  parameter int NUM_DIR      = 3,
  parameter int GREEN_TICKS  = 5,
  parameter int YELLOW_TICKS = 2,
  parameter int ALLRED_TICKS = 1,
  localparam int DW = $clog2(NUM_DIR)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               hold,
`ifdef TRAFFIC_PREEMPT_EN
  input  logic               preempt,
  input  logic [DW-1:0]      preempt_dir,
`endif
  output logic [NUM_DIR-1:0] g,
  output logic [NUM_DIR-1:0] y,
  output logic [NUM_DIR-1:0] r,
  output logic [DW-1:0]      active_dir,
  output logic [1:0]         phase
);

  localparam int MAXT =
    max3(GREEN_TICKS, YELLOW_TICKS, ALLRED_TICKS);
  localparam int CW = $clog2(MAXT) + 1;

  localparam logic [CW-1:0] G_T = CW'(GREEN_TICKS - 1);
  localparam logic [CW-1:0] Y_T = CW'(YELLOW_TICKS - 1);
  localparam logic [CW-1:0] A_T =
    CW'((ALLRED_TICKS > 0) ? ALLRED_TICKS - 1 : 0);

  phase_t               phase_q;
  phase_t               phase_d;
  logic [DW-1:0]        dir_q;
  logic [DW-1:0]        dir_d;
  logic [DW-1:0]        rr;
  logic [DW-1:0]        nxt;
  logic                 load;
  logic                 inc;
  logic                 at_term;
  logic [CW-1:0]        term;
  logic                 own;
  logic                 oth;
  logic [NUM_DIR-1:0]   one_d;
  logic [NUM_DIR-1:0]   g_d;
  logic [NUM_DIR-1:0]   y_d;

  assign rr = DW'(next_dir(32'(dir_q), NUM_DIR));

`ifdef TRAFFIC_PREEMPT_EN
  localparam logic [DW:0] NDW = (DW + 1)'(NUM_DIR);

  logic          pv;
  logic          pend_vld;
  logic [DW-1:0] pend_dir;

  assign pv  = preempt && ({1'b0, preempt_dir} < NDW);
  assign own = pv && (preempt_dir == dir_q);
  assign oth = pv && !own;
  assign nxt = pv       ? preempt_dir :
               pend_vld ? pend_dir    : rr;

  // Remember a pre-emption target until the next green is entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_vld <= 1'b0;
      pend_dir <= '0;
    end else if (tick) begin
      if (phase_d == PH_GREEN && phase_q != PH_GREEN) begin
        pend_vld <= 1'b0;
      end else if (pv && !(phase_q == PH_GREEN && own)) begin
        pend_vld <= 1'b1;
        pend_dir <= preempt_dir;
      end
    end
  end
`else
  assign own = 1'b0;
  assign oth = 1'b0;
  assign nxt = rr;
`endif

  // Terminal count for the phase currently running.
  always_comb begin
    term = A_T;
    unique case (phase_q)
      PH_GREEN:  term = G_T;
      PH_YELLOW: term = Y_T;
      default:   term = A_T;
    endcase
  end

  traffic_phase_timer #(
    .W (CW)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .load    (load),
    .inc     (inc),
    .term    (term),
    .at_term (at_term)
  );

  // Phase sequencing; everything advances only on a tick.
  always_comb begin
    phase_d = phase_q;
    dir_d   = dir_q;
    load    = 1'b0;
    inc     = 1'b0;
    if (tick) begin
      unique case (phase_q)
        PH_GREEN: begin
          if (oth) begin
            phase_d = PH_YELLOW;
            load    = 1'b1;
          end else if (own) begin
            phase_d = PH_GREEN;
          end else if (at_term && !hold) begin
            phase_d = PH_YELLOW;
            load    = 1'b1;
          end else begin
            inc = 1'b1;
          end
        end
        PH_YELLOW: begin
          if (at_term) begin
            load = 1'b1;
            if (ALLRED_TICKS == 0) begin
              phase_d = PH_GREEN;
              dir_d   = nxt;
            end else begin
              phase_d = PH_ALLRED;
            end
          end else begin
            inc = 1'b1;
          end
        end
        PH_ALLRED: begin
          if (at_term) begin
            phase_d = PH_GREEN;
            dir_d   = nxt;
            load    = 1'b1;
          end else begin
            inc = 1'b1;
          end
        end
        default: begin
          phase_d = PH_GREEN;
          load    = 1'b1;
        end
      endcase
    end
  end

  // Lamp pattern for the upcoming state; inactive approaches stay red.
  always_comb begin
    one_d = NUM_DIR'(1) << dir_d;
    g_d   = (phase_d == PH_GREEN)  ? one_d : '0;
    y_d   = (phase_d == PH_YELLOW) ? one_d : '0;
  end

  // State and lamp registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= PH_GREEN;
      dir_q   <= '0;
      g       <= NUM_DIR'(1);
      y       <= '0;
      r       <= ~NUM_DIR'(1);
    end else if (tick) begin
      phase_q <= phase_d;
      dir_q   <= dir_d;
      g       <= g_d;
      y       <= y_d;
      r       <= ~(g_d | y_d);
    end
  end

  assign active_dir = dir_q;
  assign phase      = phase_q;

endmodule

// File: tb/tb_traffic_light_ndir.sv
// Scoreboard bench for traffic_light_ndir (default and ALLRED_TICKS=0).
// Stimulus queues expected lamp states; a monitor drains after each tick.
module tb_traffic_light_ndir;

  localparam int GAP = 100;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick = 1'b0;
  logic       hold = 1'b0;
`ifdef TRAFFIC_PREEMPT_EN
  logic       preempt = 1'b0;
  logic [1:0] pdir = 2'd0;
`endif

  logic [2:0] g0, y0, r0, g1, y1, r1;
  logic [1:0] ad0, ph0, ad1, ph1;

  traffic_light_ndir u_dut (
    .clk        (clk),
`ifdef TRAFFIC_PREEMPT_EN
    .preempt    (preempt),
    .preempt_dir(pdir),
`endif
    .rst        (rst),
    .tick       (tick),
    .hold       (hold),
    .g          (g0),
    .y          (y0),
    .r          (r0),
    .active_dir (ad0),
    .phase      (ph0)
  );

  traffic_light_ndir #(.ALLRED_TICKS(0)) u_ar0 (
    .clk        (clk),
`ifdef TRAFFIC_PREEMPT_EN
    .preempt    (preempt),
    .preempt_dir(pdir),
`endif
    .rst        (rst),
    .tick       (tick),
    .hold       (hold),
    .g          (g1),
    .y          (y1),
    .r          (r1),
    .active_dir (ad1),
    .phase      (ph1)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         sel;
    logic [1:0] ph;
    logic [1:0] dir;
    logic [2:0] g;
    logic [2:0] y;
    logic [2:0] r;
    string      tag;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  event chk_ev;

  logic [1:0] tbl8[8] = '{2'd0, 2'd0, 2'd0, 2'd0,
                          2'd0, 2'd1, 2'd1, 2'd2};
  logic [1:0] tbl7[7] = '{2'd0, 2'd0, 2'd0, 2'd0,
                          2'd0, 2'd1, 2'd1};

  function automatic exp_t mk(bit sel, logic [1:0] ph,
                              logic [1:0] dir, string tag);
    exp_t e;
    logic [2:0] one;
    one   = 3'b001 << dir;
    e.sel = sel;
    e.ph  = ph;
    e.dir = dir;
    e.g   = (ph == 2'd0) ? one : 3'b000;
    e.y   = (ph == 2'd1) ? one : 3'b000;
    e.r   = ~(e.g | e.y);
    e.tag = tag;
    return e;
  endfunction

  function automatic exp_t rst_exp(bit sel, string tag);
    exp_t e;
    e.sel = sel;
    e.ph  = 2'd0;
    e.dir = 2'd0;
    e.g   = 3'b001;
    e.y   = 3'b000;
    e.r   = 3'b110;
    e.tag = tag;
    return e;
  endfunction

  task automatic drain();
    exp_t e;
    logic [12:0] a, x;
    while (q.size() > 0) begin
      e = q.pop_front();
      if (e.sel) a = {ph1, ad1, g1, y1, r1};
      else       a = {ph0, ad0, g0, y0, r0};
      x = {e.ph, e.dir, e.g, e.y, e.r};
      n_cmp++;
      if (a !== x) begin
        n_bad++;
        $display("FAIL %s: got ph=%0d dir=%0d g=%b y=%b r=%b want ph=%0d dir=%0d g=%b y=%b r=%b",
                 e.tag, a[12:11], a[10:9], a[8:6], a[5:3], a[2:0],
                 x[12:11], x[10:9], x[8:6], x[5:3], x[2:0]);
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or chk_ev);
      #1;
      drain();
    end
  end

  task automatic tick1();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    repeat (GAP - 2) @(negedge clk);
  endtask

  task automatic do_reset(string tag);
    q.push_back(rst_exp(1'b0, tag));
    q.push_back(rst_exp(1'b1, {tag, "_ar0"}));
    rst = 1'b1;
    -> chk_ev;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic rot(int n, bit both, string tag);
    for (int k = 1; k <= n; k++) begin
      q.push_back(mk(1'b0, tbl8[k % 8], 2'((k / 8) % 3),
                     $sformatf("%s%0d", tag, k)));
      if (both)
        q.push_back(mk(1'b1, tbl7[k % 7], 2'((k / 7) % 3),
                       $sformatf("%s_ar0_%0d", tag, k)));
      tick1();
    end
  endtask

  initial begin
    #(3_000_000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] eph, edir;
    q.push_back(rst_exp(1'b0, "reset"));
    q.push_back(rst_exp(1'b1, "reset_ar0"));
    #1 rst = 1'b1;
    -> chk_ev;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    hold = 1'b1;
`ifdef TRAFFIC_PREEMPT_EN
    preempt = 1'b1;
    pdir    = 2'd1;
`endif
    repeat (40) @(negedge clk);
    q.push_back(rst_exp(1'b0, "no_tick"));
    -> chk_ev;
    @(negedge clk);
    hold = 1'b0;
`ifdef TRAFFIC_PREEMPT_EN
    preempt = 1'b0;
    pdir    = 2'd0;
`endif
    @(negedge clk);

    rot(24, 1'b1, "rot");

    do_reset("rst_hold");
    for (int k = 1; k <= 14; k++) begin
      hold = ((k >= 3 && k <= 10) || k == 12 || k == 13);
      eph  = (k <= 10) ? 2'd0 : (k <= 12) ? 2'd1 :
             (k == 13) ? 2'd2 : 2'd0;
      edir = (k == 14) ? 2'd1 : 2'd0;
      q.push_back(mk(1'b0, eph, edir, $sformatf("hold%0d", k)));
      tick1();
    end
    hold = 1'b0;

    do_reset("rst_a");
    rot(21, 1'b0, "pre");
    do_reset("mid_rst");
    rot(5, 1'b0, "post");

`ifdef TRAFFIC_PREEMPT_EN
    begin
      logic [1:0] p6[23] = '{
        2'd0, 2'd1, 2'd1, 2'd2,
        2'd0, 2'd0, 2'd0, 2'd0, 2'd0,
        2'd0, 2'd0, 2'd0, 2'd0, 2'd0,
        2'd1, 2'd1, 2'd2,
        2'd0, 2'd0, 2'd0, 2'd0, 2'd0,
        2'd1};
      logic [1:0] d6[23] = '{
        2'd0, 2'd0, 2'd0, 2'd0,
        2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd2, 2'd2, 2'd2,
        2'd0, 2'd0, 2'd0, 2'd0, 2'd0,
        2'd0};
      do_reset("rst_pre");
      for (int k = 1; k <= 23; k++) begin
        preempt = (k >= 2 && k <= 10) || (k >= 19);
        pdir    = (k >= 19) ? 2'd3 : 2'd2;
        q.push_back(mk(1'b0, p6[k-1], d6[k-1],
                       $sformatf("preempt%0d", k)));
        tick1();
      end
      preempt = 1'b0;
      pdir    = 2'd0;
    end
`endif

    for (int i = 0; i < 1000 && q.size() > 0; i++)
      @(negedge clk);
    n_cmp++;
    if (q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
